// File: rtl/case_5_prod_accum_if.sv
// Stream bundle for the product accumulator: product input channel and
// frame-sum output channel, each with its own valid/ready handshake.
interface case_5_prod_accum_if #(
  parameter int DIN_WIDTH = 10,
  parameter int ACC_WIDTH = 16
);
  logic [DIN_WIDTH-1:0] din;
  logic                 din_vld;
  logic                 din_rdy;
  logic [ACC_WIDTH-1:0] dout;
  logic                 dout_vld;
  logic                 dout_rdy;
  logic                 dout_ovf;

  modport master (
    output din, din_vld, dout_rdy,
    input  din_rdy, dout, dout_vld, dout_ovf
  );

  modport slave (
    input  din, din_vld, dout_rdy,
    output din_rdy, dout, dout_vld, dout_ovf
  );
endinterface

// File: rtl/case_5_prod_accum.sv
// Frame accumulator behind the signed multiplier: sums FRAME_LEN products and
// presents the wrapped sum plus an overflow flag on a backpressured output.
module case_5_prod_accum #(
  parameter int DIN_WIDTH = 10,
  parameter int ACC_WIDTH = 16,
  parameter int FRAME_LEN = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  frame_clr,
  case_5_prod_accum_if.slave    s
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(FRAME_LEN - 1);

  // Two's-complement overflow: like-signed operands yield an opposite-signed sum.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

  logic [0:0]                  state_r;
  logic signed [ACC_WIDTH-1:0] acc_r;
  logic [CNT_WIDTH-1:0]        cnt_r;
  logic                        ovf_sticky_r;
  logic [ACC_WIDTH-1:0]        dout_r;
  logic                        dout_ovf_r;
  logic                        dout_vld_r;
  logic                        din_rdy_r;

  logic signed [ACC_WIDTH-1:0] din_ext_s;
  logic signed [ACC_WIDTH-1:0] sum_s;
  logic                        ovf_s;
  logic                        accept_s;

  assign din_ext_s = ACC_WIDTH'($signed(s.din));
  assign sum_s     = acc_r + din_ext_s;
  assign ovf_s     = add_ovf(acc_r[ACC_WIDTH-1], din_ext_s[ACC_WIDTH-1], sum_s[ACC_WIDTH-1]);
  assign accept_s  = s.din_vld & din_rdy_r;

  assign s.din_rdy  = din_rdy_r;
  assign s.dout     = dout_r;
  assign s.dout_vld = dout_vld_r;
  assign s.dout_ovf = dout_ovf_r;

  // Frame FSM, accumulator and registered output stage.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_r      <= ACCUM;
      acc_r        <= '0;
      cnt_r        <= '0;
      ovf_sticky_r <= 1'b0;
      dout_r       <= '0;
      dout_ovf_r   <= 1'b0;
      dout_vld_r   <= 1'b0;
      din_rdy_r    <= 1'b1;
    end else begin
      case (state_r)
        ACCUM: begin
          // Abort outranks a coincident sample, which is dropped.
          if (frame_clr) begin
            acc_r        <= '0;
            cnt_r        <= '0;
            ovf_sticky_r <= 1'b0;
          end else if (accept_s) begin
            if (cnt_r == LAST_CNT) begin
              dout_r       <= sum_s;
              dout_ovf_r   <= ovf_sticky_r | ovf_s;
              acc_r        <= '0;
              cnt_r        <= '0;
              ovf_sticky_r <= 1'b0;
              state_r      <= HOLD;
              dout_vld_r   <= 1'b1;
              din_rdy_r    <= 1'b0;
            end else begin
              acc_r        <= sum_s;
              cnt_r        <= cnt_r + CNT_WIDTH'(1);
              ovf_sticky_r <= ovf_sticky_r | ovf_s;
            end
          end else begin
            acc_r <= acc_r;
          end
        end
        HOLD: begin
          // Result stays put until consumed; frame_clr has no effect here.
          if (s.dout_rdy) begin
            state_r    <= ACCUM;
            dout_vld_r <= 1'b0;
            din_rdy_r  <= 1'b1;
          end else begin
            dout_vld_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= ACCUM;
          acc_r        <= '0;
          cnt_r        <= '0;
          ovf_sticky_r <= 1'b0;
          dout_vld_r   <= 1'b0;
          din_rdy_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_case_5_prod_accum.sv
// Directed bench for case_5_prod_accum: three configurations (4-sample/16-bit,
// 2-sample/10-bit wrap, 1-sample) driven with hand-computed frames.
module tb_case_5_prod_accum;

  logic ap_clk;
  logic ap_rst;
  logic frame_clr;
  int   n_checks;
  int   n_fail;

  case_5_prod_accum_if #(.DIN_WIDTH(10), .ACC_WIDTH(16)) ifa ();
  case_5_prod_accum_if #(.DIN_WIDTH(10), .ACC_WIDTH(10)) ifb ();
  case_5_prod_accum_if #(.DIN_WIDTH(10), .ACC_WIDTH(16)) ifc ();

  case_5_prod_accum #(.DIN_WIDTH(10), .ACC_WIDTH(16), .FRAME_LEN(4), .CNT_WIDTH(4)) u_a (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .frame_clr(frame_clr), .s(ifa.slave));
  case_5_prod_accum #(.DIN_WIDTH(10), .ACC_WIDTH(10), .FRAME_LEN(2), .CNT_WIDTH(2)) u_b (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .frame_clr(frame_clr), .s(ifb.slave));
  case_5_prod_accum #(.DIN_WIDTH(10), .ACC_WIDTH(16), .FRAME_LEN(1), .CNT_WIDTH(1)) u_c (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .frame_clr(frame_clr), .s(ifc.slave));

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send_a(input logic [9:0] v);
    ifa.din = v; ifa.din_vld = 1'b1;
    cycle();
    ifa.din_vld = 1'b0;
  endtask

  task automatic send_b(input logic [9:0] v);
    ifb.din = v; ifb.din_vld = 1'b1;
    cycle();
    ifb.din_vld = 1'b0;
  endtask

  task automatic send_c(input logic [9:0] v);
    ifc.din = v; ifc.din_vld = 1'b1;
    cycle();
    ifc.din_vld = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    ap_rst = 1'b1; frame_clr = 1'b0;
    ifa.din = 10'd0; ifa.din_vld = 1'b0; ifa.dout_rdy = 1'b0;
    ifb.din = 10'd0; ifb.din_vld = 1'b0; ifb.dout_rdy = 1'b0;
    ifc.din = 10'd0; ifc.din_vld = 1'b0; ifc.dout_rdy = 1'b0;
    cycle(); cycle();
    ap_rst = 1'b0;
    cycle();
    check_eq("rst_a_rdy", 32'(ifa.din_rdy), 32'd1);
    check_eq("rst_a_vld", 32'(ifa.dout_vld), 32'd0);
    check_eq("rst_a_dout", 32'(ifa.dout), 32'd0);
    check_eq("rst_a_ovf", 32'(ifa.dout_ovf), 32'd0);
    check_eq("rst_b_rdy", 32'(ifb.din_rdy), 32'd1);
    check_eq("rst_c_vld", 32'(ifc.dout_vld), 32'd0);

    // T1: 1+2+3+4, one-cycle output pulse
    ifa.dout_rdy = 1'b1;
    send_a(10'd1); send_a(10'd2); send_a(10'd3);
    check_eq("t1_vld_early", 32'(ifa.dout_vld), 32'd0);
    send_a(10'd4);
    check_eq("t1_vld", 32'(ifa.dout_vld), 32'd1);
    check_eq("t1_dout", 32'(ifa.dout), 32'd10);
    check_eq("t1_ovf", 32'(ifa.dout_ovf), 32'd0);
    check_eq("t1_rdy_hold", 32'(ifa.din_rdy), 32'd0);
    cycle();
    check_eq("t1_vld_drop", 32'(ifa.dout_vld), 32'd0);
    check_eq("t1_rdy_back", 32'(ifa.din_rdy), 32'd1);

    // T2: -512 x4 = -2048
    for (int i = 0; i < 4; i++) send_a(10'h200);
    check_eq("t2_vld", 32'(ifa.dout_vld), 32'd1);
    check_eq("t2_dout", 32'(ifa.dout), 32'h0000F800);
    check_eq("t2_ovf", 32'(ifa.dout_ovf), 32'd0);
    cycle();

    // T3: 10-bit wrap, then sticky cleared on next frame
    ifb.dout_rdy = 1'b1;
    send_b(10'd300); send_b(10'd300);
    check_eq("t3_vld", 32'(ifb.dout_vld), 32'd1);
    check_eq("t3_dout", 32'(ifb.dout), 32'h00000258);
    check_eq("t3_ovf", 32'(ifb.dout_ovf), 32'd1);
    cycle();
    send_b(10'd1); send_b(10'd1);
    check_eq("t3_dout2", 32'(ifb.dout), 32'd2);
    check_eq("t3_ovf2", 32'(ifb.dout_ovf), 32'd0);
    cycle();

    // T4: backpressure with a waiting sample
    ifa.dout_rdy = 1'b0;
    send_a(10'd5); send_a(10'd6); send_a(10'd7); send_a(10'd8);
    ifa.din = 10'd100; ifa.din_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t4_rdy_low", 32'(ifa.din_rdy), 32'd0);
      check_eq("t4_vld_held", 32'(ifa.dout_vld), 32'd1);
      check_eq("t4_dout_held", 32'(ifa.dout), 32'd26);
      cycle();
    end
    ifa.dout_rdy = 1'b1;
    cycle();
    check_eq("t4_release_vld", 32'(ifa.dout_vld), 32'd0);
    check_eq("t4_release_rdy", 32'(ifa.din_rdy), 32'd1);
    cycle();
    ifa.din_vld = 1'b0;
    send_a(10'd1); send_a(10'd2); send_a(10'd3);
    check_eq("t4_next_vld", 32'(ifa.dout_vld), 32'd1);
    check_eq("t4_next_dout", 32'(ifa.dout), 32'd106);
    cycle();

    // T5: abort mid-frame (coincident sample dropped), clear ignored in HOLD
    send_a(10'd9); send_a(10'd9);
    frame_clr = 1'b1; ifa.din = 10'd50; ifa.din_vld = 1'b1;
    cycle();
    frame_clr = 1'b0; ifa.din_vld = 1'b0;
    ifa.dout_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_a(10'd5);
    check_eq("t5_dout", 32'(ifa.dout), 32'd20);
    frame_clr = 1'b1;
    cycle();
    frame_clr = 1'b0;
    check_eq("t5_clr_hold_vld", 32'(ifa.dout_vld), 32'd1);
    check_eq("t5_clr_hold_dout", 32'(ifa.dout), 32'd20);
    ifa.dout_rdy = 1'b1;
    cycle();
    check_eq("t5_delivered", 32'(ifa.dout_vld), 32'd0);

    // T6: reset mid-frame and in HOLD
    send_a(10'd7); send_a(10'd7);
    ap_rst = 1'b1;
    cycle();
    ap_rst = 1'b0;
    check_eq("t6_mid_vld", 32'(ifa.dout_vld), 32'd0);
    check_eq("t6_mid_rdy", 32'(ifa.din_rdy), 32'd1);
    for (int i = 0; i < 4; i++) send_a(10'd1);
    check_eq("t6_post_dout", 32'(ifa.dout), 32'd4);
    cycle();
    ifa.dout_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_a(10'd2);
    check_eq("t6_hold_vld", 32'(ifa.dout_vld), 32'd1);
    check_eq("t6_hold_dout", 32'(ifa.dout), 32'd8);
    ap_rst = 1'b1;
    cycle();
    ap_rst = 1'b0;
    check_eq("t6_hold_rst_vld", 32'(ifa.dout_vld), 32'd0);
    check_eq("t6_hold_rst_dout", 32'(ifa.dout), 32'd0);
    check_eq("t6_hold_rst_rdy", 32'(ifa.din_rdy), 32'd1);
    ifa.dout_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send_a(10'd3);
    check_eq("t6_after_dout", 32'(ifa.dout), 32'd12);
    cycle();

    // FRAME_LEN=1: each sample is a frame, sign extended
    ifc.dout_rdy = 1'b1;
    send_c(10'h3FD);
    check_eq("f1_vld", 32'(ifc.dout_vld), 32'd1);
    check_eq("f1_dout_neg", 32'(ifc.dout), 32'h0000FFFD);
    check_eq("f1_rdy", 32'(ifc.din_rdy), 32'd0);
    cycle();
    send_c(10'd511);
    check_eq("f1_dout_pos", 32'(ifc.dout), 32'h000001FF);
    check_eq("f1_ovf", 32'(ifc.dout_ovf), 32'd0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
